// File: rtl/fusion_unit_pipe.sv
// Pipelined bit-brick MAC: 2b bricks, runtime full/half/quarter operand widths, lane-packed psum.
// Optional lane saturation enabled by defining FUSION_SAT_EN.
module fusion_unit_pipe #(
  parameter int MAX_W  = 8,
  parameter int PSUM_W = 52
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_in_sel,
  input  logic [1:0]        cfg_wt_sel,
  input  logic              cfg_s_in,
  input  logic              cfg_s_weight,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAX_W-1:0]  in_data,
  input  logic [MAX_W-1:0]  weight,
  input  logic [PSUM_W-1:0] psum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] psum_out,
  output logic              ovf_out
);
  localparam int NB     = MAX_W / 2;
  localparam int NP     = NB * NB;
  localparam int LOG_NB = $clog2(NB);
  localparam int PW     = 2 * MAX_W + 2;
  localparam int SW     = PSUM_W + PW;

  logic [1:0] in_sel_q, wt_sel_q;
  logic       s_in_q, s_wt_q;
  logic [2:1] vld_pipe;
  logic       s1_adv, s2_adv, accept;
  logic [LOG_NB:0] ib_m, wb_m;
  logic signed [PW-1:0] prod    [NP];
  logic signed [PW-1:0] s1_prod [NP];
  logic [1:0]           lane_of [NB];
  logic [PSUM_W-1:0]    s1_psum, nxt_psum;

  assign s2_adv    = !vld_pipe[2] | out_ready;
  assign s1_adv    = !vld_pipe[1] | s2_adv;
  assign in_ready  = s1_adv & !cfg_valid;
  assign accept    = in_valid & in_ready;
  assign cfg_ready = !vld_pipe[1] & !vld_pipe[2];
  assign out_valid = vld_pipe[2];

  // Bricks per sub-operand minus one; doubles as the position mask within a sub-operand.
  assign ib_m = ((LOG_NB+1)'(NB) >> in_sel_q) - (LOG_NB+1)'(1);
  assign wb_m = ((LOG_NB+1)'(NB) >> wt_sel_q) - (LOG_NB+1)'(1);

  for (genvar q = 0; q < NB; q++) begin : g_lane
    assign lane_of[q] = 2'((LOG_NB)'(q) >> (LOG_NB - int'(wt_sel_q)));
  end

  // The top brick of a signed sub-operand is a signed digit; every other brick is unsigned.
  for (genvar p = 0; p < NB; p++) begin : g_p
    for (genvar q = 0; q < NB; q++) begin : g_q
      logic [LOG_NB:0]   ipos, jpos;
      logic [LOG_NB+1:0] sh;
      logic signed [2:0] av, wv;
      assign ipos = (LOG_NB+1)'(p) & ib_m;
      assign jpos = (LOG_NB+1)'(q) & wb_m;
      assign av   = {s_in_q & (ipos == ib_m) & in_data[2*p+1], in_data[2*p+1 -: 2]};
      assign wv   = {s_wt_q & (jpos == wb_m) & weight[2*q+1], weight[2*q+1 -: 2]};
      assign sh   = {1'b0, ipos} + {1'b0, jpos};
      assign prod[p*NB+q] = (PW'(av) * PW'(wv)) <<< {sh, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_prod <= prod;
      s1_psum <= psum_in;
    end
  end

  int                 lw;
  logic               sgn;
  logic signed [SW-1:0] mask, lane_in, acc, res;
`ifdef FUSION_SAT_EN
  logic signed [SW-1:0] hi, lo;
  logic                 nxt_ovf;
`endif

  // Lanes are summed wide so clipping can be seen before folding back to LW bits.
  always_comb begin
    nxt_psum = '0;
    lw       = PSUM_W >> wt_sel_q;
    sgn      = s_in_q | s_wt_q;
    mask     = (SW'(1) << lw) - SW'(1);
    lane_in  = '0;
    acc      = '0;
    res      = '0;
`ifdef FUSION_SAT_EN
    nxt_ovf  = 1'b0;
    hi       = '0;
    lo       = '0;
`endif
    for (int j = 0; j < 4; j++) begin
      if (j < (1 << wt_sel_q)) begin
        lane_in = (SW'(s1_psum) >> (j * lw)) & mask;
        if (sgn && lane_in[lw-1]) lane_in = lane_in | ~mask;
        acc = lane_in;
        for (int k = 0; k < NP; k++)
          if (lane_of[k % NB] == 2'(j)) acc = acc + SW'(s1_prod[k]);
        res = acc & mask;
`ifdef FUSION_SAT_EN
        if (sgn) begin
          hi = mask >>> 1;
          lo = ~hi;
        end else begin
          hi = mask;
          lo = '0;
        end
        if (acc > hi) begin
          res = hi;
          nxt_ovf = 1'b1;
        end else if (acc < lo) begin
          res = lo & mask;
          nxt_ovf = 1'b1;
        end
`endif
        nxt_psum = nxt_psum | PSUM_W'(res << (j * lw));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      psum_out <= '0;
      cfg_err  <= 1'b0;
      in_sel_q <= 2'd0;
      wt_sel_q <= 2'd0;
      s_in_q   <= 1'b0;
      s_wt_q   <= 1'b0;
`ifdef FUSION_SAT_EN
      ovf_out  <= 1'b0;
`endif
    end else begin
      if (cfg_valid && cfg_ready) begin
        if (cfg_in_sel == 2'd3 || cfg_wt_sel == 2'd3) cfg_err <= 1'b1;
        else begin
          in_sel_q <= cfg_in_sel;
          wt_sel_q <= cfg_wt_sel;
          s_in_q   <= cfg_s_in;
          s_wt_q   <= cfg_s_weight;
        end
      end
      if (s1_adv) vld_pipe[1] <= accept;
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          psum_out <= nxt_psum;
`ifdef FUSION_SAT_EN
          ovf_out  <= nxt_ovf;
`endif
        end
      end
    end
  end

`ifndef FUSION_SAT_EN
  assign ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_fusion_unit_pipe.sv
// Directed + scoreboard bench for fusion_unit_pipe (MAX_W=8, PSUM_W=52).
module tb_fusion_unit_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0, cfg_ready;
  logic [1:0]  cfg_in_sel = 2'd0, cfg_wt_sel = 2'd0;
  logic        cfg_s_in = 1'b0, cfg_s_weight = 1'b0, cfg_err;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_data = '0, weight = '0;
  logic [51:0] psum_in = '0;
  logic        out_valid, out_ready = 1'b1, ovf_out;
  logic [51:0] psum_out;

  fusion_unit_pipe #(.MAX_W(8), .PSUM_W(52)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_sel(cfg_in_sel), .cfg_wt_sel(cfg_wt_sel), .cfg_s_in(cfg_s_in),
    .cfg_s_weight(cfg_s_weight), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .weight(weight), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out), .ovf_out(ovf_out));

  always #5 clk = ~clk;

  typedef struct packed { logic [51:0] psum; logic ovf; } exp_t;
  exp_t q[$];
  int n_assert = 0, n_fail = 0;
  int m_is = 0, m_ws = 0;
  bit m_si = 0, m_sw = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: direct per-sub-operand arithmetic, lane by lane.
  function automatic exp_t model(int is, int ws, bit si, bit sw, logic [7:0] a,
                                 logic [7:0] w, logic [51:0] ps);
    exp_t e;
    int iw, ww, nl, lw;
    longint m, lane, ai, wj;
`ifdef FUSION_SAT_EN
    longint hi, lo;
`endif
    iw = 8 >> is; ww = 8 >> ws; nl = 8 / ww; lw = 52 / nl;
    e.psum = '0; e.ovf = 1'b0;
    m = (longint'(1) << lw) - 1;
    for (int j = 0; j < nl; j++) begin
      lane = longint'(ps >> (j * lw)) & m;
      if ((si || sw) && ((lane >> (lw - 1)) & 1) == 1) lane = lane - (longint'(1) << lw);
      wj = longint'(w >> (j * ww)) & ((longint'(1) << ww) - 1);
      if (sw && wj >= (longint'(1) << (ww - 1))) wj = wj - (longint'(1) << ww);
      for (int i = 0; i < 8 / iw; i++) begin
        ai = longint'(a >> (i * iw)) & ((longint'(1) << iw) - 1);
        if (si && ai >= (longint'(1) << (iw - 1))) ai = ai - (longint'(1) << iw);
        lane = lane + ai * wj;
      end
`ifdef FUSION_SAT_EN
      if (si || sw) begin hi = (longint'(1) << (lw - 1)) - 1; lo = -hi - 1; end
      else begin hi = m; lo = 0; end
      if (lane > hi) begin lane = hi; e.ovf = 1'b1; end
      else if (lane < lo) begin lane = lo; e.ovf = 1'b1; end
`endif
      e.psum = e.psum | (52'(lane & m) << (j * lw));
    end
    return e;
  endfunction

  // Scoreboard: check head every valid cycle (covers stall stability), push on accept.
  task mon;
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          chk("psum_out", 64'(psum_out), 64'(q[0].psum));
          chk("ovf_out", 64'(ovf_out), 64'(q[0].ovf));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(m_is, m_ws, m_si, m_sw, in_data, weight, psum_in));
      if (cfg_valid && cfg_ready && cfg_in_sel != 2'd3 && cfg_wt_sel != 2'd3) begin
        m_is = int'(cfg_in_sel); m_ws = int'(cfg_wt_sel); m_si = cfg_s_in; m_sw = cfg_s_weight;
      end
    end
  endtask

  task nedge; @(negedge clk); mon(); endtask
  task pedge; @(posedge clk); #1; endtask
  task tick;  nedge(); pedge(); endtask

  task automatic do_cfg(input int is, input int ws, input bit si, input bit sw);
    bit ok = 0;
    cfg_valid = 1'b1; cfg_in_sel = 2'(is); cfg_wt_sel = 2'(ws);
    cfg_s_in = si; cfg_s_weight = sw;
    for (int k = 0; k < 20 && !ok; k++) begin nedge(); ok = cfg_ready; pedge(); end
    cfg_valid = 1'b0;
    chk("cfg_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic [51:0] ps);
    bit ok = 0;
    in_valid = 1'b1; in_data = a; weight = w; psum_in = ps;
    for (int k = 0; k < 20 && !ok; k++) begin nedge(); ok = in_ready; pedge(); end
    in_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_out(input string tag, input logic [51:0] ep, input logic eo);
    bit ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      nedge();
      if (out_valid) begin
        ok = 1;
        chk(tag, 64'(psum_out), 64'(ep));
        chk({tag, "_ovf"}, 64'(ovf_out), 64'(eo));
      end
      pedge();
    end
    chk({tag, "_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit ok;
    int k;
    logic [7:0]  ra [4];
    logic [7:0]  rw [4];
    logic [51:0] rp [4];

    pedge(); pedge();
    rst = 1'b0;
    nedge();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_psum_out", 64'(psum_out), 64'd0);
    chk("rst_ovf_out", 64'(ovf_out), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    pedge();

    // 8b/8b signed with latency check
    do_cfg(0, 0, 1, 1);
    send(8'hFF, 8'h03, 52'd10);
    nedge(); chk("lat_edge1", 64'(out_valid), 64'd0); pedge();
    nedge(); chk("lat_edge2", 64'(out_valid), 64'd1);
    chk("s8_psum", 64'(psum_out), 64'd7); pedge();

    do_cfg(1, 1, 0, 0);
    send(8'h21, 8'h53, 52'd0);
    wait_out("u4_psum", {26'd15, 26'd9}, 1'b0);

    do_cfg(2, 2, 0, 0);
    send(8'hFF, 8'hE4, 52'd0);
    wait_out("u2_psum", {13'd36, 13'd24, 13'd12, 13'd0}, 1'b0);

    send(8'hFF, 8'hE4, {13'd8190, 39'd0});
`ifdef FUSION_SAT_EN
    wait_out("sat_psum", {13'd8191, 13'd24, 13'd12, 13'd0}, 1'b1);
`else
    wait_out("wrap_psum", {13'd34, 13'd24, 13'd12, 13'd0}, 1'b0);
`endif

    // Backpressure: 4 back-to-back beats, out_ready low for 3 clocks
    do_cfg(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'($urandom); rw[i] = 8'($urandom); rp[i] = 52'({$urandom(), $urandom()});
    end
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      in_valid = 1'b1; in_data = ra[k]; weight = rw[k]; psum_in = rp[k];
      if (c >= 3) out_ready = 1'b1;
      nedge();
      if (c == 2) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      if (in_ready) k++;
      pedge();
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(k), 64'd4);
    drain();

    // Config waits for drain; same-cycle config wins over a beat
    for (int i = 0; i < 3; i++) begin
      ra[i] = 8'($urandom); rw[i] = 8'($urandom); rp[i] = 52'({$urandom(), $urandom()});
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = ra[i]; weight = rw[i]; psum_in = rp[i];
      nedge(); chk("tie_pre_accept", 64'(in_ready), 64'd1); pedge();
    end
    in_data = ra[2]; weight = rw[2]; psum_in = rp[2];
    cfg_valid = 1'b1; cfg_in_sel = 2'd1; cfg_wt_sel = 2'd2; cfg_s_in = 1'b1; cfg_s_weight = 1'b0;
    nedge();
    chk("cfg_ready_busy", 64'(cfg_ready), 64'd0);
    chk("tie_in_ready", 64'(in_ready), 64'd0);
    pedge();
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      nedge(); ok = cfg_ready;
      if (ok) chk("tie_in_ready_hs", 64'(in_ready), 64'd0);
      pedge();
    end
    cfg_valid = 1'b0;
    chk("cfg_drain_hs", 64'(ok), 64'd1);
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin nedge(); ok = in_ready; pedge(); end
    in_valid = 1'b0;
    chk("tie_beat_after", 64'(ok), 64'd1);
    drain();

    // Illegal select: handshake completes, sticky error, config unchanged
    do_cfg(3, 1, 0, 0);
    nedge(); chk("cfg_err_set", 64'(cfg_err), 64'd1); pedge();
    send(8'($urandom), 8'($urandom), 52'({$urandom(), $urandom()}));
    drain();

    // Random configs, random backpressure
    for (int r = 0; r < 4; r++) begin
      do_cfg($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'($urandom));
      k = 0;
      in_valid = 1'b1; in_data = 8'($urandom); weight = 8'($urandom);
      psum_in = 52'({$urandom(), $urandom()});
      for (int c = 0; c < 60 && k < 6; c++) begin
        out_ready = 1'($urandom);
        nedge();
        if (in_ready) begin
          k++;
          pedge();
          in_data = 8'($urandom); weight = 8'($urandom);
          psum_in = 52'({$urandom(), $urandom()});
        end else pedge();
      end
      in_valid = 1'b0;
      chk("rand_accepted", 64'(k), 64'd6);
      drain();
    end

    // Reset with two beats in flight
    do_cfg(0, 0, 0, 0);
    out_ready = 1'b0;
    send(8'h12, 8'h34, 52'd5);
    send(8'h56, 8'h78, 52'd6);
    rst = 1'b1; q.delete();
    m_is = 0; m_ws = 0; m_si = 0; m_sw = 0;
    nedge(); pedge();
    rst = 1'b0;
    nedge();
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    chk("rst_flush_psum", 64'(psum_out), 64'd0);
    pedge();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nedge(); chk("rst_no_ghost", 64'(out_valid), 64'd0); pedge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
